// File: rtl/serial_bit_feeder_if.sv
// Word-load handshake and serial output bundle for serial_bit_feeder.
// The upstream/bench side uses the master modport; the feeder uses the slave modport.
interface serial_bit_feeder_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] data_in;
  logic             load_valid;
  logic             load_ready;
  logic             x;
  logic             x_valid;
  logic             busy;
  logic             done;

  modport master (
    output data_in, load_valid,
    input  load_ready, x, x_valid, busy, done
  );

  modport slave (
    input  data_in, load_valid,
    output load_ready, x, x_valid, busy, done
  );
endinterface

// File: rtl/serial_bit_feeder.sv
// Parallel-to-serial MSB-first feeder with gapless back-to-back words.
// Optional trailing even-parity bit per word: define SERIAL_BIT_FEEDER_PARITY_EN.
module serial_bit_feeder #(
  parameter int   WIDTH    = 8,
  parameter logic IDLE_BIT = 1'b0
) (
  input  logic                 clock,
  input  logic                 reset,
  serial_bit_feeder_if.slave   bus
);
  localparam int CW = $clog2(WIDTH);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q;
  logic [WIDTH-1:0] sr_q;
  logic [CW-1:0]    cnt_q;
  logic             x_q;
  logic             x_valid_q;
  logic             last_s;
  logic             ready_s;
  logic             accept_s;

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  logic par_q;
  logic par_phase_q;

  function automatic logic even_parity(input logic [WIDTH-1:0] w);
    return ^w;
  endfunction

  // The final cycle of a word is the parity bit, not the LSB.
  assign last_s = (state_q == SHIFT) && (cnt_q == {CW{1'b0}}) && par_phase_q;
`else
  assign last_s = (state_q == SHIFT) && (cnt_q == {CW{1'b0}});
`endif

  assign ready_s  = (state_q == IDLE) || last_s;
  assign accept_s = bus.load_valid && ready_s;

  // Reset gates ready so nothing appears acceptable while the block is held.
  assign bus.load_ready = !reset && ready_s;
  assign bus.busy       = (state_q == SHIFT);
  assign bus.done       = last_s;
  assign bus.x          = x_q;
  assign bus.x_valid    = x_valid_q;

  // Word load / shift state machine with registered serial outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sr_q        <= {WIDTH{1'b0}};
      cnt_q       <= {CW{1'b0}};
      x_q         <= IDLE_BIT;
      x_valid_q   <= 1'b0;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
      par_q       <= 1'b0;
      par_phase_q <= 1'b0;
`endif
    end else if (accept_s) begin
      state_q     <= SHIFT;
      x_q         <= bus.data_in[WIDTH-1];
      x_valid_q   <= 1'b1;
      sr_q        <= {bus.data_in[WIDTH-2:0], 1'b0};
      cnt_q       <= CW'(WIDTH - 1);
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
      par_q       <= even_parity(bus.data_in);
      par_phase_q <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          x_q       <= IDLE_BIT;
          x_valid_q <= 1'b0;
        end
        SHIFT: begin
          if (cnt_q != {CW{1'b0}}) begin
            x_q   <= sr_q[WIDTH-1];
            sr_q  <= {sr_q[WIDTH-2:0], 1'b0};
            cnt_q <= cnt_q - CW'(1);
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
          end else if (!par_phase_q) begin
            x_q         <= par_q;
            par_phase_q <= 1'b1;
`endif
          end else begin
            state_q   <= IDLE;
            x_q       <= IDLE_BIT;
            x_valid_q <= 1'b0;
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
            par_phase_q <= 1'b0;
`endif
          end
        end
        default: begin
          state_q   <= IDLE;
          x_q       <= IDLE_BIT;
          x_valid_q <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_serial_bit_feeder.sv
// Directed, table-driven bench for serial_bit_feeder (WIDTH=8 and WIDTH=4/IDLE_BIT=1).
module tb_serial_bit_feeder;
  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

`ifdef SERIAL_BIT_FEEDER_PARITY_EN
  localparam int PX = 1;
`else
  localparam int PX = 0;
`endif

  serial_bit_feeder_if #(.WIDTH(8)) bus8 ();
  serial_bit_feeder_if #(.WIDTH(4)) bus4 ();

  serial_bit_feeder #(.WIDTH(8), .IDLE_BIT(1'b0)) u8 (.clock(clock), .reset(reset), .bus(bus8));
  serial_bit_feeder #(.WIDTH(4), .IDLE_BIT(1'b1)) u4 (.clock(clock), .reset(reset), .bus(bus4));

  typedef struct {
    logic       lv;
    logic [7:0] d;
    logic       x;
    logic       xv;
    logic       rdy;
    logic       bsy;
    logic       dn;
  } vec_t;

  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  function automatic void add(logic lv, logic [7:0] d, logic x, logic xv,
                              logic rdy, logic bsy, logic dn);
    vec_t v;
    v.lv = lv; v.d = d; v.x = x; v.xv = xv; v.rdy = rdy; v.bsy = bsy; v.dn = dn;
    tbl.push_back(v);
  endfunction

  function automatic void add_idle(logic lv, logic [7:0] d);
    add(lv, d, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
  endfunction

  // One word on x: expected bits MSB-first, parity bit p, load_valid asserted from entry lv_from on.
  function automatic void add_word(logic [7:0] bits, logic p, int lv_from, logic [7:0] d);
    int n = 8 + PX;
    for (int i = 0; i < n; i++) begin
      logic b;
      logic lst;
      b   = (i < 8) ? bits[7-i] : p;
      lst = (i == n - 1);
      add(i >= lv_from, (i >= lv_from) ? d : 8'h00, b, 1'b1, lst, 1'b1, lst);
    end
  endfunction

  task automatic chk(string nm, logic act, logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic check8(string tag, logic x, logic xv, logic rdy, logic bsy, logic dn);
    chk({tag, ".x"},          bus8.x,          x);
    chk({tag, ".x_valid"},    bus8.x_valid,    xv);
    chk({tag, ".load_ready"}, bus8.load_ready, rdy);
    chk({tag, ".busy"},       bus8.busy,       bsy);
    chk({tag, ".done"},       bus8.done,       dn);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    logic [7:0] e8;
    logic [3:0] e4;
    int         n;

    bus8.load_valid = 1'b0; bus8.data_in = 8'h00;
    bus4.load_valid = 1'b0; bus4.data_in = 4'h0;

    // Vector table: single word, back-to-back across a boundary, mid-word request.
    add_idle(1'b1, 8'hB0);
    add_word(8'b1011_0000, 1'b1, 99, 8'h00);
    add_idle(1'b0, 8'h00);
    add_idle(1'b1, 8'h0B);
    add_word(8'b0000_1011, 1'b1, 0, 8'hD0);
    add_word(8'b1101_0000, 1'b1, 99, 8'h00);
    add_idle(1'b0, 8'h00);
    add_idle(1'b1, 8'h00);
    add_word(8'b0000_0000, 1'b0, 2, 8'hFF);
    add_word(8'b1111_1111, 1'b0, 99, 8'h00);
    add_idle(1'b0, 8'h00);
`ifdef SERIAL_BIT_FEEDER_PARITY_EN
    add_idle(1'b1, 8'h07);
    add_word(8'b0000_0111, 1'b1, 99, 8'h00);
    add_idle(1'b0, 8'h00);
`endif

    repeat (2) @(posedge clock);
    #1;
    check8("reset_held", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    tick();

    for (int i = 0; i < tbl.size(); i++) begin
      bus8.load_valid = tbl[i].lv;
      bus8.data_in    = tbl[i].d;
      check8($sformatf("vec%0d", i), tbl[i].x, tbl[i].xv, tbl[i].rdy, tbl[i].bsy, tbl[i].dn);
      tick();
    end

    // Asynchronous reset during bit 4 of 8'hA5, then a clean 8'h5A.
    bus8.load_valid = 1'b1; bus8.data_in = 8'hA5;
    tick();
    bus8.load_valid = 1'b0;
    repeat (3) tick();
    chk("a5_bit4.x_valid", bus8.x_valid, 1'b1);
    chk("a5_bit4.busy",    bus8.busy,    1'b1);
    #2;
    reset = 1'b1;
    #1;
    check8("async_reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check8("post_reset", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    bus8.load_valid = 1'b1; bus8.data_in = 8'h5A;
    tick();
    bus8.load_valid = 1'b0;
    e8 = 8'b0101_1010;
    n  = 8 + PX;
    for (int i = 0; i < n; i++) begin
      check8($sformatf("w5a_%0d", i), (i < 8) ? e8[7-i] : 1'b0, 1'b1,
             i == n - 1, 1'b1, i == n - 1);
      tick();
    end
    check8("w5a_idle", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);

    // WIDTH=4, IDLE_BIT=1 instance with 4'h9.
    chk("w4_idle.x",          bus4.x,          1'b1);
    chk("w4_idle.load_ready", bus4.load_ready, 1'b1);
    bus4.load_valid = 1'b1; bus4.data_in = 4'h9;
    tick();
    bus4.load_valid = 1'b0;
    e4 = 4'b1001;
    n  = 4 + PX;
    for (int i = 0; i < n; i++) begin
      chk($sformatf("w4_%0d.x", i),       bus4.x,       (i < 4) ? e4[3-i] : 1'b0);
      chk($sformatf("w4_%0d.x_valid", i), bus4.x_valid, 1'b1);
      chk($sformatf("w4_%0d.done", i),    bus4.done,    i == n - 1);
      tick();
    end
    chk("w4_after.x",       bus4.x,       1'b1);
    chk("w4_after.x_valid", bus4.x_valid, 1'b0);
    chk("w4_after.busy",    bus4.busy,    1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
